// File: rtl/vec_csr_pkg.sv
// Shared types for the vector configuration CSR unit.
// Fractional LMUL support is selected by VEC_FRAC_LMUL_EN.
package vec_csr_pkg;

    typedef enum logic [2:0] {
        LMUL1   = 3'd0,
        LMUL2   = 3'd1,
        LMUL4   = 3'd2,
        LMUL8   = 3'd3,
        RSVD    = 3'd4,
        LMUL_F8 = 3'd5,
        LMUL_F4 = 3'd6,
        LMUL_F2 = 3'd7
    } vlmul_e;

    typedef enum logic [2:0] {
        SEW8  = 3'd0,
        SEW16 = 3'd1,
        SEW32 = 3'd2,
        SEW64 = 3'd3
    } vsew_e;

    typedef struct packed {
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        vlmul_e     vlmul;
    } vtype_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } cfg_state_e;

    // vill set, every other field zero (32-bit view)
    localparam logic [31:0] VTYPE_ILLEGAL = 32'h8000_0000;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational vtype legality check and VLMAX via log2 arithmetic.
// Fractional LMUL legality is governed by VEC_FRAC_LMUL_EN.
module vec_vlmax_calc
    import vec_csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic [XLEN-2:0] i_vtype,
    output logic [XLEN-1:0] o_vlmax,
    output logic            o_illegal
);

    localparam logic signed [7:0] LOG_VLEN = 8'($clog2(VLEN));
    localparam logic signed [7:0] LOG_ELEN = 8'($clog2(ELEN));

    vtype_t            w_vt;
    logic signed [7:0] w_sew_log;
    logic signed [7:0] w_lmul_log;
    logic signed [7:0] w_vl_log;
    logic              w_frac;
    logic              w_rsvd_bits;
    logic              w_frac_bad;

    assign w_vt      = vtype_t'(i_vtype[7:0]);
    assign w_sew_log = 8'sd3 + $signed({5'd0, w_vt.vsew});

    always_comb begin
        w_lmul_log = 8'sd0;
        w_frac     = 1'b0;
        unique case (w_vt.vlmul)
            LMUL1:   w_lmul_log = 8'sd0;
            LMUL2:   w_lmul_log = 8'sd1;
            LMUL4:   w_lmul_log = 8'sd2;
            LMUL8:   w_lmul_log = 8'sd3;
            RSVD:    w_lmul_log = 8'sd0;
            LMUL_F8: begin w_lmul_log = -8'sd3; w_frac = 1'b1; end
            LMUL_F4: begin w_lmul_log = -8'sd2; w_frac = 1'b1; end
            LMUL_F2: begin w_lmul_log = -8'sd1; w_frac = 1'b1; end
        endcase
    end

    // log2(VLMAX) = log2(VLEN) - log2(SEW) + log2(LMUL)
    assign w_vl_log    = LOG_VLEN - w_sew_log + w_lmul_log;
    assign w_rsvd_bits = |i_vtype[XLEN-2:8];

`ifdef VEC_FRAC_LMUL_EN
    assign w_frac_bad = w_frac &&
                        ((w_vl_log < 8'sd0) ||
                         (w_sew_log > LOG_ELEN + w_lmul_log));
`else
    assign w_frac_bad = w_frac;
`endif

    assign o_illegal = w_rsvd_bits
                     | (w_vt.vsew > 3'(SEW64))
                     | (w_sew_log > LOG_ELEN)
                     | (w_vt.vlmul == RSVD)
                     | w_frac_bad;

    assign o_vlmax = o_illegal ? '0
                   : ({{(XLEN-1){1'b0}}, 1'b1} << $unsigned(w_vl_log));

endmodule

// File: rtl/vec_csr_config.sv
// vl/vtype/vstart CSR unit: IDLE -> CALC -> COMMIT for vset* requests.
// Build with VEC_FRAC_LMUL_EN to accept fractional LMUL.
module vec_csr_config
    import vec_csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_req_valid,
    output logic            cfg_req_ready,
    input  logic [XLEN-1:0] scalar1,
    input  logic [XLEN-1:0] scalar2,
    input  logic            avl_is_imm,
    input  logic            rs1_is_x0,
    input  logic            rd_is_x0,
    output logic            cfg_done,
    output logic [XLEN-1:0] cfg_rd_data,
    input  logic            vstart_wr_en,
    input  logic [XLEN-1:0] vstart_wr_data,
    input  logic            vstart_clr,
    output logic [XLEN-1:0] csr_vl,
    output logic [XLEN-1:0] csr_vtype,
    output logic [XLEN-1:0] csr_vstart,
    output logic [6:0]      csr_sew,
    output logic            csr_vill
);

    localparam logic [XLEN-1:0] VTYPE_RST =
        XLEN'(VTYPE_ILLEGAL) << (XLEN - 32);

    cfg_state_e      r_state;
    logic [XLEN-1:0] r_avl;
    logic [XLEN-2:0] r_vtype_raw;
    logic            r_avl_imm;
    logic            r_rs1_x0;
    logic            r_rd_x0;
    logic [XLEN-1:0] r_vlmax;
    logic            r_ill;
    logic [XLEN-1:0] r_vl;
    logic [XLEN-1:0] r_vtype;
    logic [XLEN-1:0] r_vstart;

    logic [XLEN-1:0] w_vlmax;
    logic            w_ill;
    logic [XLEN-1:0] w_min;
    logic [XLEN-1:0] w_cap;
    logic [XLEN-1:0] w_new_vl;
    logic [XLEN-1:0] w_new_vtype;
    logic            w_commit;
    logic            w_unused_vill;

    // the incoming vill bit carries no meaning on a write
    assign w_unused_vill = scalar2[XLEN-1];

    vec_vlmax_calc #(
        .XLEN (XLEN),
        .VLEN (VLEN),
        .ELEN (ELEN)
    ) u_calc (
        .i_vtype   (r_vtype_raw),
        .o_vlmax   (w_vlmax),
        .o_illegal (w_ill)
    );

    assign w_commit = (r_state == S_COMMIT);
    assign w_min    = (r_avl < r_vlmax) ? r_avl : r_vlmax;
    assign w_cap    = (r_vl > r_vlmax) ? r_vlmax : r_vl;

    always_comb begin
        w_new_vl = '0;
        priority case (1'b1)
            r_ill:                    w_new_vl = '0;
            (r_avl_imm | ~r_rs1_x0):  w_new_vl = w_min;
            ~r_rd_x0:                 w_new_vl = r_vlmax;
            default:                  w_new_vl = w_cap;
        endcase
    end

    assign w_new_vtype = r_ill ? VTYPE_RST
                       : {{(XLEN-8){1'b0}}, r_vtype_raw[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_avl       <= '0;
            r_vtype_raw <= '0;
            r_avl_imm   <= 1'b0;
            r_rs1_x0    <= 1'b0;
            r_rd_x0     <= 1'b0;
            r_vlmax     <= '0;
            r_ill       <= 1'b0;
            r_vl        <= '0;
            r_vtype     <= VTYPE_RST;
            r_vstart    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_req_valid) begin
                        r_avl       <= scalar1;
                        r_vtype_raw <= scalar2[XLEN-2:0];
                        r_avl_imm   <= avl_is_imm;
                        r_rs1_x0    <= rs1_is_x0;
                        r_rd_x0     <= rd_is_x0;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_vlmax <= w_vlmax;
                    r_ill   <= w_ill;
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_vl    <= w_new_vl;
                    r_vtype <= w_new_vtype;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_commit)
                r_vstart <= '0;
            else if (vstart_clr)
                r_vstart <= '0;
            else if (vstart_wr_en)
                r_vstart <= vstart_wr_data;
        end
    end

    assign cfg_req_ready = (r_state == S_IDLE);
    assign cfg_done      = w_commit;
    assign cfg_rd_data   = w_commit ? w_new_vl : '0;
    assign csr_vl        = r_vl;
    assign csr_vtype     = r_vtype;
    assign csr_vstart    = r_vstart;
    assign csr_vill      = r_vtype[XLEN-1];
    assign csr_sew       = 7'd8 << r_vtype[4:3];

endmodule
